bitcoin_hash: RTL and testbench
===============================

BITCOIN_HASH -- requirements
Module: bitcoin_hash

Interface
REQ-001 SHALL have parameter NUM_NONCES, default 16: number of nonces hashed per run (nonce values 0..NUM_NONCES-1).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock, rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: synchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin a run; level-sampled.
REQ-005 SHALL have port message_addr, input, 32 bits: word address of the 19-word header.
REQ-006 SHALL have port output_addr, input, 32 bits: word address of the result array.
REQ-007 SHALL have port done, output, 1 bit: run complete.
REQ-008 SHALL have port mem_clk, output, 1 bit: memory clock, driven as clk.
REQ-009 SHALL have port mem_we, output, 1 bit: memory write enable; 0 means read.
REQ-010 SHALL have port mem_addr, output, 16 bits: memory word address.
REQ-011 SHALL have port mem_write_data, output, 32 bits: memory write data.
REQ-012 SHALL have port mem_read_data, input, 32 bits: memory read data.

Function
REQ-013 SHALL sample start only in IDLE; start while busy is ignored.
REQ-014 SHALL latch message_addr and output_addr when a run starts.
REQ-015 SHALL use these states: IDLE -> READ (19 header words) -> BLK1 -> BLK2 -> HASH2 -> WRITE.
- After WRITE: loop to BLK2 for the next nonce, or go to DONE after the last nonce.
- DONE -> IDLE.
REQ-016 SHALL treat memory reads as one-cycle latency: an address presented in cycle t returns mem_read_data that is sampled at the end of cycle t+1.
REQ-017 SHALL commit a write at the rising edge ending the cycle in which mem_we=1; mem_addr and mem_write_data are valid in that same cycle.
REQ-018 SHALL form mem_addr from the low 16 bits of the base address plus the offset, wrapping modulo 2^16.
REQ-019 SHALL run first hash block 1 as standard SHA-256 compression of header words 0..15, starting from the SHA-256 initial hash value (IV).
REQ-020 SHALL run first hash block 2 per nonce n on this message schedule, chained from the block-1 digest:
- header words 16..18;
- word 19 = n;
- word 20 = 0x80000000;
- words 21..30 = 0;
- word 31 = 640.
REQ-021 SHALL run the second hash per nonce as SHA-256 of the 8-word first-hash digest, from the IV, with padding:
- word 8 = 0x80000000;
- words 9..14 = 0;
- word 15 = 256.
REQ-022 SHALL write word H0 of the second-hash digest for nonce n to output_addr+n; no other memory writes are permitted.
REQ-023 SHALL compute one SHA-256 round per clock and expand the message schedule on the fly (16-word sliding window).
REQ-024 SHALL perform all additions modulo 2^32.
REQ-025 SHALL raise done in DONE and hold it high until the next accepted start or reset; done is 0 at all other times.
REQ-026 SHALL drive mem_we=0 whenever it is not writing.

Reset
REQ-027 SHALL, while reset_n=0 at a clk edge, set:
- state=IDLE;
- done=0, mem_we=0;
- mem_addr=0, mem_write_data=0;
- the nonce counter to 0.
REQ-028 SHALL abort any run on reset mid-operation; there are no further writes until a new start.

Configuration
REQ-029 SHALL support macro BITCOIN_HASH_PRECOMP_EN.
- Defined: the block-1 digest is computed once per run and reused for all nonces; total latency from start to done is at most 2600 cycles for NUM_NONCES=16.
- Undefined: block 1 is recomputed for each nonce; results are identical and latency is at most 3700 cycles.

Structure
REQ-030 SHALL place the following in package bitcoin_hash_pkg:
- the 64 SHA-256 K constants;
- the 8 IV words;
- the state enum typedef;
- the rightrotate and round functions.
REQ-031 SHALL use one sub-module, sha256_block: a 64-round compression engine with start/done, 8-word input hash, and 16-word block input.

Verification
REQ-032 SHALL verify the base run: header = seed 0x01234567, each next word = rotl1 of the previous; message_addr=0, output_addr=1000.
- Addresses 1000..1015 must match the golden model.
- done=1.
- There are no writes outside 1000..1015.
REQ-033 SHALL verify base addresses: message_addr=200, output_addr=5000, seed 0xDEADBEEF.
- Addresses 5000..5015 must be correct.
- Addresses 200..218 must be unmodified.
REQ-034 SHALL verify reset mid-run: assert reset_n=0 at cycle 500 of a run.
- On the next edge: done=0 and mem_we=0.
- A subsequent start must complete correctly.
REQ-035 SHALL verify that start is ignored while busy: pulse start 5 times during BLK2.
- Results must be identical to a single run.
- done must rise exactly once.
REQ-036 SHALL verify back-to-back runs: after done, rerun with seed 0x00000000.
- Outputs must match the model for an all-zero header.
REQ-037 SHALL verify both builds: run with and without BITCOIN_HASH_PRECOMP_EN.
- Outputs must be identical in both builds.
- Cycle counts must be within the REQ-029 bounds.

Source files
------------

// File: rtl/bitcoin_hash_pkg.sv
// Shared SHA-256 constants, types and round arithmetic for the bitcoin_hash nonce search.
package bitcoin_hash_pkg;

  // Word i of a hash lives at index i (a..h during rounds, H0..H7 as digest).
  typedef logic [7:0][31:0]  hash_t;
  typedef logic [15:0][31:0] block_t;

  typedef enum logic [2:0] {IDLE, READ, BLK1, BLK2, HASH2, WRITE, DONE} state_t;

  localparam int HDR_WORDS = 19;

  localparam hash_t IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                          32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rightrotate(input logic [31:0] x, input int r);
    return (x >> r) | (x << (32 - r));
  endfunction

  function automatic hash_t sha256_round(input hash_t s, input logic [31:0] w, input logic [31:0] k);
    logic [31:0] s1, ch, t1, s0, maj, t2;
    hash_t n;
    s1  = rightrotate(s[4], 6) ^ rightrotate(s[4], 11) ^ rightrotate(s[4], 25);
    ch  = (s[4] & s[5]) ^ (~s[4] & s[6]);
    t1  = s[7] + s1 + ch + k + w;
    s0  = rightrotate(s[0], 2) ^ rightrotate(s[0], 13) ^ rightrotate(s[0], 22);
    maj = (s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]);
    t2  = s0 + maj;
    n[0] = t1 + t2;
    n[1] = s[0];
    n[2] = s[1];
    n[3] = s[2];
    n[4] = s[3] + t1;
    n[5] = s[4];
    n[6] = s[5];
    n[7] = s[6];
    return n;
  endfunction

  // W[t+16] from the window holding W[t..t+15] at indices 0..15.
  function automatic logic [31:0] next_w(input block_t w);
    logic [31:0] s0, s1;
    s0 = rightrotate(w[1], 7) ^ rightrotate(w[1], 18) ^ (w[1] >> 3);
    s1 = rightrotate(w[14], 17) ^ rightrotate(w[14], 19) ^ (w[14] >> 10);
    return w[0] + s0 + w[9] + s1;
  endfunction

endpackage

// File: rtl/sha256_block.sv
// One SHA-256 compression: one round per clock, schedule expanded in a 16-word sliding window.
module sha256_block
  import bitcoin_hash_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   start,
  input  hash_t  hash_in,
  input  block_t block,
  output logic   done,
  output hash_t  hash_out
);

  logic       busy;
  logic [5:0] rnd;
  hash_t      hin;
  hash_t      st;
  block_t     win;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy <= 1'b0;
      rnd  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        rnd  <= '0;
      end else if (busy) begin
        rnd <= rnd + 6'd1;
        if (rnd == 6'd63) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      hin <= hash_in;
      st  <= hash_in;
      win <= block;
    end else if (busy) begin
      st  <= sha256_round(st, win[0], K[rnd]);
      win <= {next_w(win), win[15:1]};
    end
  end

  // Digest stays valid from the done pulse until the next start.
  always_comb begin
    for (int i = 0; i < 8; i++) hash_out[i] = hin[i] + st[i];
  end

endmodule

// File: rtl/bitcoin_hash.sv
// Double SHA-256 over a 19-word header for nonces 0..NUM_NONCES-1, writing H0 of each result.
// Define BITCOIN_HASH_PRECOMP_EN to compute the first header block once per run.
module bitcoin_hash
  import bitcoin_hash_pkg::*;
#(
  parameter int NUM_NONCES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] message_addr,
  input  logic [31:0] output_addr,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  state_t      state, state_next;
  logic [31:0] hdr [HDR_WORDS];
  logic [15:0] msg_base, out_base;
  logic [4:0]  rd_cnt;
  logic [15:0] nonce;
  logic        last_nonce;
  logic        blk_go, blk_done;
  hash_t       blk_hash_in, blk_hash_out, mid, dig1;
  block_t      blk_block;
  logic        unused_addr_hi;

  assign mem_clk        = clk;
  assign last_nonce     = (nonce == 16'(NUM_NONCES - 1));
  assign unused_addr_hi = ^{message_addr[31:16], output_addr[31:16]};

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start) state_next = READ;
      READ:  if (rd_cnt == 5'(HDR_WORDS)) state_next = BLK1;
      BLK1:  if (blk_done) state_next = BLK2;
      BLK2:  if (blk_done) state_next = HASH2;
      HASH2: if (blk_done) state_next = WRITE;
      WRITE: begin
        if (last_nonce) state_next = DONE;
        else
`ifdef BITCOIN_HASH_PRECOMP_EN
          state_next = BLK2;
`else
          state_next = BLK1;
`endif
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      done           <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      nonce          <= '0;
      rd_cnt         <= '0;
      blk_go         <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      blk_go <= (state_next != state) && (state_next inside {BLK1, BLK2, HASH2});
      if (state == IDLE && start) begin
        done     <= 1'b0;
        nonce    <= '0;
        rd_cnt   <= '0;
        mem_addr <= message_addr[15:0];
      end
      // Read data lags its address by one cycle, so word i lands while rd_cnt = i+1.
      if (state == READ) begin
        rd_cnt   <= rd_cnt + 5'd1;
        mem_addr <= msg_base + 16'(rd_cnt) + 16'd1;
      end
      if (state == HASH2 && blk_done) begin
        mem_we         <= 1'b1;
        mem_addr       <= out_base + nonce;
        mem_write_data <= blk_hash_out[0];
      end
      if (state == WRITE && !last_nonce) nonce <= nonce + 16'd1;
      if (state_next == DONE) done <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      msg_base <= message_addr[15:0];
      out_base <= output_addr[15:0];
    end
    if (state == READ && rd_cnt != 5'd0) hdr[rd_cnt - 5'd1] <= mem_read_data;
    if (state == BLK1 && blk_done) mid  <= blk_hash_out;
    if (state == BLK2 && blk_done) dig1 <= blk_hash_out;
  end

  // Engine inputs only need to be valid in the cycle blk_go is high.
  always_comb begin
    blk_hash_in = IV;
    blk_block   = '0;
    if (state == BLK1) begin
      for (int i = 0; i < 16; i++) blk_block[i] = hdr[i];
    end else if (state == BLK2) begin
      blk_hash_in   = mid;
      blk_block[0]  = hdr[16];
      blk_block[1]  = hdr[17];
      blk_block[2]  = hdr[18];
      blk_block[3]  = 32'(nonce);
      blk_block[4]  = 32'h80000000;
      blk_block[15] = 32'd640;
    end else if (state == HASH2) begin
      for (int i = 0; i < 8; i++) blk_block[i] = dig1[i];
      blk_block[8]  = 32'h80000000;
      blk_block[15] = 32'd256;
    end
  end

  sha256_block u_sha256_block (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (blk_go),
    .hash_in  (blk_hash_in),
    .block    (blk_block),
    .done     (blk_done),
    .hash_out (blk_hash_out)
  );

endmodule

// File: tb/tb_bitcoin_hash.sv
// Directed bench for bitcoin_hash: independent SHA-256 model, word memory, table of runs plus corner sequences.
module tb_bitcoin_hash;

  localparam int NN = 16;
`ifdef BITCOIN_HASH_PRECOMP_EN
  localparam int LAT_MAX = 2600;
`else
  localparam int LAT_MAX = 3700;
`endif

  typedef logic [7:0][31:0]  h8_t;
  typedef logic [15:0][31:0] b16_t;

  typedef struct {
    logic [31:0]       seed;
    logic [31:0]       maddr;
    logic [31:0]       oaddr;
    logic [15:0][31:0] exp;
  } vec_t;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] IVW [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] message_addr, output_addr;
  logic        done, mem_clk, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data, mem_read_data;

  logic [31:0] mem [65536];
  logic        tb_we = 1'b0;
  logic [15:0] tb_addr = '0;
  logic [31:0] tb_data = '0;
  logic [15:0] cur_out = '0;
  int          wr_cnt = 0, bad_wr = 0, done_rises = 0;
  logic        done_q = 1'b0;
  int          checks = 0, failures = 0;
  vec_t        vecs [4];

  bitcoin_hash #(.NUM_NONCES(NN)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .message_addr   (message_addr),
    .output_addr    (output_addr),
    .done           (done),
    .mem_clk        (mem_clk),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge mem_clk) begin
    mem_read_data <= mem[mem_addr];
    if (mem_we) begin
      mem[mem_addr] <= mem_write_data;
      wr_cnt <= wr_cnt + 1;
      if (16'(mem_addr - cur_out) >= 16'(NN)) bad_wr <= bad_wr + 1;
    end else if (tb_we) begin
      mem[tb_addr] <= tb_data;
    end
  end

  always @(posedge clk) begin
    done_q <= done;
    if (done === 1'b1 && done_q === 1'b0) done_rises <= done_rises + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=no_finish required=finish");
    $fatal(1);
  end

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic h8_t iv_h();
    h8_t h;
    for (int i = 0; i < 8; i++) h[i] = IVW[i];
    return h;
  endfunction

  function automatic h8_t compress(input h8_t hv, input b16_t blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    h8_t r;
    for (int t = 0; t < 16; t++) w[t] = blk[t];
    for (int t = 16; t < 64; t++)
      w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
    e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
    for (int t = 0; t < 64; t++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    r[0] = hv[0] + a; r[1] = hv[1] + b; r[2] = hv[2] + c; r[3] = hv[3] + d;
    r[4] = hv[4] + e; r[5] = hv[5] + f; r[6] = hv[6] + g; r[7] = hv[7] + h;
    return r;
  endfunction

  function automatic logic [31:0] hdr_word(input logic [31:0] seed, input int i);
    logic [31:0] x;
    x = seed;
    for (int j = 0; j < i; j++) x = {x[30:0], x[31]};
    return x;
  endfunction

  function automatic logic [31:0] model_h0(input logic [31:0] seed, input int n);
    b16_t b;
    h8_t  mid, d1, d2;
    for (int i = 0; i < 16; i++) b[i] = hdr_word(seed, i);
    mid = compress(iv_h(), b);
    b = '0;
    b[0] = hdr_word(seed, 16); b[1] = hdr_word(seed, 17); b[2] = hdr_word(seed, 18);
    b[3] = 32'(n); b[4] = 32'h80000000; b[15] = 32'd640;
    d1 = compress(mid, b);
    b = '0;
    for (int i = 0; i < 8; i++) b[i] = d1[i];
    b[8] = 32'h80000000; b[15] = 32'd256;
    d2 = compress(iv_h(), b);
    return d2[0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_le(input string name, input int act, input int max);
    checks++;
    if (act > max) begin
      failures++;
      $display("FAIL %s actual=%0d required<=%0d", name, act, max);
    end
  endtask

  task automatic load_region(input logic [31:0] seed, input logic [15:0] mb, input logic [15:0] ob);
    for (int i = 0; i < 19; i++) begin
      @(negedge clk); tb_we = 1'b1; tb_addr = mb + 16'(i); tb_data = hdr_word(seed, i);
    end
    for (int i = 0; i < NN; i++) begin
      @(negedge clk); tb_we = 1'b1; tb_addr = ob + 16'(i); tb_data = 32'hA5A55A5A;
    end
    @(negedge clk); tb_we = 1'b0;
  endtask

  task automatic run_check(input string name, input logic [31:0] seed, input logic [31:0] maddr,
                           input logic [31:0] oaddr, input logic [15:0][31:0] exp, input bit busy_pulses);
    int cyc, wr0, bad0, rise0, nbad;
    bit to;
    logic [15:0] a;
    load_region(seed, maddr[15:0], oaddr[15:0]);
    cur_out = oaddr[15:0];
    wr0 = wr_cnt; bad0 = bad_wr; rise0 = done_rises;
    message_addr = maddr; output_addr = oaddr; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; to = 1'b0;
    while (done !== 1'b1) begin
      if (busy_pulses && cyc >= 100 && cyc <= 140 && (cyc % 10) == 0) begin
        start = 1'b1; message_addr = maddr ^ 32'h40; output_addr = oaddr ^ 32'h80;
      end else begin
        start = 1'b0; message_addr = maddr; output_addr = oaddr;
      end
      @(negedge clk);
      cyc++;
      if (cyc > 6000) begin to = 1'b1; break; end
    end
    start = 1'b0;
    check({name, "_timeout"}, 32'(to), 32'd0);
    check_le({name, "_latency"}, cyc, LAT_MAX);
    repeat (5) @(negedge clk);
    check({name, "_done_hold"}, 32'(done), 32'd1);
    check({name, "_done_rises"}, 32'(done_rises - rise0), 32'd1);
    check({name, "_write_count"}, 32'(wr_cnt - wr0), 32'(NN));
    check({name, "_stray_writes"}, 32'(bad_wr - bad0), 32'd0);
    for (int n = 0; n < NN; n++) begin
      a = oaddr[15:0] + 16'(n);
      check($sformatf("%s_out%0d", name, n), mem[a], exp[n]);
    end
    nbad = 0;
    for (int i = 0; i < 19; i++) begin
      a = maddr[15:0] + 16'(i);
      if (mem[a] !== hdr_word(seed, i)) nbad++;
    end
    check({name, "_hdr_intact"}, 32'(nbad), 32'd0);
  endtask

  initial begin
    h8_t d;
    b16_t b;
    int wr0;
    logic [15:0][31:0] exp_r;

    vecs[0].seed = 32'h01234567; vecs[0].maddr = 32'd0;        vecs[0].oaddr = 32'd1000;
    vecs[1].seed = 32'hDEADBEEF; vecs[1].maddr = 32'd200;      vecs[1].oaddr = 32'd5000;
    vecs[2].seed = 32'h00000000; vecs[2].maddr = 32'd0;        vecs[2].oaddr = 32'd1000;
    vecs[3].seed = 32'h89ABCDEF; vecs[3].maddr = 32'h1234FFFA; vecs[3].oaddr = 32'hABCD0100;
    for (int v = 0; v < 4; v++)
      for (int n = 0; n < NN; n++) vecs[v].exp[n] = model_h0(vecs[v].seed, n);
    for (int n = 0; n < NN; n++) exp_r[n] = model_h0(32'h13579BDF, n);

    b = '0; b[0] = 32'h61626380; b[15] = 32'h18;
    d = compress(iv_h(), b);
    check("model_abc_h0", d[0], 32'hba7816bf);
    check("model_abc_h7", d[7], 32'hf20015ad);

    reset_n = 1'b0; start = 1'b0; message_addr = '0; output_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_write_data, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 4; v++)
      run_check($sformatf("vec%0d", v), vecs[v].seed, vecs[v].maddr, vecs[v].oaddr, vecs[v].exp, 1'b0);

    run_check("busy_start", vecs[0].seed, vecs[0].maddr, vecs[0].oaddr, vecs[0].exp, 1'b1);

    load_region(32'h13579BDF, 16'd300, 16'd2000);
    cur_out = 16'd2000;
    message_addr = 32'd300; output_addr = 32'd2000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (499) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_mem_we", 32'(mem_we), 32'd0);
    check("midrst_mem_addr", 32'(mem_addr), 32'd0);
    wr0 = wr_cnt;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    repeat (300) @(negedge clk);
    check("midrst_no_writes", 32'(wr_cnt - wr0), 32'd0);
    check("midrst_done_low", 32'(done), 32'd0);
    run_check("after_rst", 32'h13579BDF, 32'd300, 32'd2000, exp_r, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
